vga_timing_600p: RTL and testbench

//  SVGA 800x600@60 raster timing generator in the clk_pix (40 MHz) domain.

---
 rtl/vga_timing_600p.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_600p.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_600p.sv
// SVGA 800x600@60 raster timing generator running in the pixel-clock domain.
// Waits for the pixel clock to lock, then free-runs the (sx,sy) raster and
// produces registered hsync/vsync/de and line/frame start strobes. A
// synchronised loss of lock aborts the frame and returns to idle immediately.
module vga_timing_600p #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1
) (
  input  logic        clk_pix,
  input  logic        rst_n,
  input  logic        pix_locked,
  output logic [10:0] sx,
  output logic [9:0]  sy,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width copies of the timing boundaries so every compare is 11/10 bits.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timing sets whose totals do not fit the fixed-width counters.
  generate
    if ((H_TOTAL - 1) > 2047 || (V_TOTAL - 1) > 1023) begin : g_param_check
      $error("vga_timing_600p: H_TOTAL/V_TOTAL overflow the 11/10-bit counters");
    end
  endgenerate

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        lock_meta_q;
  logic        lock_s_q;
  logic [10:0] sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        running_q, running_d;

  // Two-flop synchroniser bringing the asynchronous lock indication into clk_pix.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pix_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state logic: the outputs are decoded from the *next* counter values so
  // that the registered outputs always describe the pixel held in sx/sy.
  always_comb begin
    state_d       = state_q;
    sx_d          = '0;
    sy_d          = '0;
    hsync_d       = ~H_POL;
    vsync_d       = ~V_POL;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d   = RUN;
          running_d = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          // Abort mid-frame: everything falls back to idle values on this edge.
          state_d = WAIT_LOCK;
        end else begin
          running_d = 1'b1;
          if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? 10'd0 : sy_q + 10'd1;
          end else begin
            sx_d = sx_q + 11'd1;
            sy_d = sy_q;
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (running_d) begin
      de_d          = (sx_d < H_VIS_END) && (sy_d < V_VIS_END);
      hsync_d       = ((sx_d >= HS_START) && (sx_d < HS_END)) ? H_POL : ~H_POL;
      vsync_d       = ((sy_d >= VS_START) && (sy_d < VS_END)) ? V_POL : ~V_POL;
      line_start_d  = (sx_d == 11'd0);
      frame_start_d = (sx_d == 11'd0) && (sy_d == 10'd0);
    end
  end

  // State, counters and decoded outputs all register together.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      sx_q          <= '0;
      sy_q          <= '0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign sx          = sx_q;
  assign sy          = sy_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_600p.sv
// Directed testbench for vga_timing_600p: a full-size SVGA instance for reset,
// lock start-up and line timing, plus a shrunken, inverted-polarity instance so
// whole frames, wraps and mid-frame lock loss fit in a short run.
module tb_vga_timing_600p;

  logic clk;
  logic rst_n;
  logic lock_a;
  logic lock_b;

  logic [10:0] sx_a, sx_b;
  logic [9:0]  sy_a, sy_b;
  logic hs_a, vs_a, de_a, ls_a, fs_a, run_a;
  logic hs_b, vs_b, de_b, ls_b, fs_b, run_b;

  int tests  = 0;
  int failed = 0;

  vga_timing_600p u_dut_a (
    .clk_pix     (clk),
    .rst_n       (rst_n),
    .pix_locked  (lock_a),
    .sx          (sx_a),
    .sy          (sy_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .de          (de_a),
    .line_start  (ls_a),
    .frame_start (fs_a),
    .running     (run_a)
  );

  // Small raster: H_TOTAL=16 (sync at sx 10..12), V_TOTAL=10 (sync at sy 7..8).
  vga_timing_600p #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .H_POL    (1'b0), .V_POL (1'b0)
  ) u_dut_b (
    .clk_pix     (clk),
    .rst_n       (rst_n),
    .pix_locked  (lock_b),
    .sx          (sx_b),
    .sy          (sy_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .de          (de_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .running     (run_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int de_cnt, de_first_low, hs_cnt, hs_first, hs_last, ls_cnt, vs_cnt, seq_err, fs_cnt;
    int vs_first, vs_last, misalign;
    logic vs_prev;

    rst_n  = 1'b1;
    lock_a = 1'b1;
    lock_b = 1'b1;

    // Asynchronous reset with lock high and no clock edge yet.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_running",  32'(run_a), 32'd0);
    chk("rst_sx",       32'(sx_a),  32'd0);
    chk("rst_sy",       32'(sy_a),  32'd0);
    chk("rst_de",       32'(de_a),  32'd0);
    chk("rst_hsync",    32'(hs_a),  32'd0);
    chk("rst_vsync",    32'(vs_a),  32'd0);
    chk("rst_ls",       32'(ls_a),  32'd0);
    chk("rst_fs",       32'(fs_a),  32'd0);
    chk("rst_hsync_neg", 32'(hs_b), 32'd1);
    chk("rst_vsync_neg", 32'(vs_b), 32'd1);

    step(2);
    chk("rst_hold_running", 32'(run_a), 32'd0);

    // Release reset with lock low: must stay idle.
    rst_n  = 1'b1;
    lock_a = 1'b0;
    lock_b = 1'b0;
    step(10);
    chk("idle_running", 32'(run_a), 32'd0);
    chk("idle_sx",      32'(sx_a),  32'd0);

    // Lock rises: RUN appears exactly on the third edge.
    lock_a = 1'b1;
    step(1);
    chk("lock_e1_running", 32'(run_a), 32'd0);
    step(1);
    chk("lock_e2_running", 32'(run_a), 32'd0);
    chk("lock_e2_fs",      32'(fs_a),  32'd0);
    step(1);
    chk("lock_e3_running", 32'(run_a), 32'd1);
    chk("lock_e3_fs",      32'(fs_a),  32'd1);
    chk("lock_e3_ls",      32'(ls_a),  32'd1);
    chk("lock_e3_sx",      32'(sx_a),  32'd0);
    chk("lock_e3_sy",      32'(sy_a),  32'd0);
    chk("lock_e3_de",      32'(de_a),  32'd1);
    chk("lock_e3_hsync",   32'(hs_a),  32'd0);
    chk("lock_e3_vsync",   32'(vs_a),  32'd0);

    // One full SVGA line observed cycle by cycle.
    de_cnt = 0; de_first_low = -1; hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; vs_cnt = 0; seq_err = 0; fs_cnt = 0;
    for (int c = 0; c < 1056; c++) begin
      if (c > 0) step(1);
      if (de_a) de_cnt++;
      else if (de_first_low < 0) de_first_low = c;
      if (hs_a) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (c > 0 && ls_a) ls_cnt++;
      if (c > 0 && fs_a) fs_cnt++;
      if (vs_a) vs_cnt++;
      if (sx_a !== 11'(c) || sy_a !== 10'd0) seq_err++;
    end
    chk("line_de_count",     32'(de_cnt),       32'd800);
    chk("line_de_first_low", 32'(de_first_low), 32'd800);
    chk("line_hs_count",     32'(hs_cnt),       32'd128);
    chk("line_hs_first",     32'(hs_first),     32'd840);
    chk("line_hs_last",      32'(hs_last),      32'd967);
    chk("line_ls_extra",     32'(ls_cnt),       32'd0);
    chk("line_fs_extra",     32'(fs_cnt),       32'd0);
    chk("line_vs_count",     32'(vs_cnt),       32'd0);
    chk("line_seq_err",      32'(seq_err),      32'd0);
    step(1);
    chk("line_wrap_ls", 32'(ls_a), 32'd1);
    chk("line_wrap_sx", 32'(sx_a), 32'd0);
    chk("line_wrap_sy", 32'(sy_a), 32'd1);
    chk("line_wrap_fs", 32'(fs_a), 32'd0);

    // Lock loss mid-line on the full-size instance.
    step(400);
    chk("a_loss_sx_before", 32'(sx_a), 32'd400);
    lock_a = 1'b0;
    step(2);
    chk("a_loss_e2_running", 32'(run_a), 32'd1);
    chk("a_loss_e2_sx",      32'(sx_a),  32'd402);
    step(1);
    chk("a_loss_e3_running", 32'(run_a), 32'd0);
    chk("a_loss_e3_sx",      32'(sx_a),  32'd0);
    chk("a_loss_e3_sy",      32'(sy_a),  32'd0);
    chk("a_loss_e3_de",      32'(de_a),  32'd0);
    lock_a = 1'b1;
    step(3);
    chk("a_relock_fs", 32'(fs_a), 32'd1);
    chk("a_relock_sx", 32'(sx_a), 32'd0);

    // Small inverted-polarity instance: lock and run one full frame.
    lock_b = 1'b1;
    step(3);
    chk("b_lock_running", 32'(run_b), 32'd1);
    chk("b_lock_fs",      32'(fs_b),  32'd1);
    de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; vs_last = -1;
    ls_cnt = 0; fs_cnt = 0; seq_err = 0; misalign = 0;
    vs_prev = vs_b;
    for (int c = 0; c < 160; c++) begin
      if (c > 0) step(1);
      if (de_b) de_cnt++;
      if (!hs_b) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
      end
      if (!vs_b) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
        vs_last = c;
      end
      if (vs_b !== vs_prev && sx_b !== 11'd0) misalign++;
      vs_prev = vs_b;
      if (ls_b) ls_cnt++;
      if (c > 0 && fs_b) fs_cnt++;
      if (sx_b !== 11'(c % 16) || sy_b !== 10'(c / 16)) seq_err++;
    end
    chk("frame_de_count",   32'(de_cnt),   32'd48);
    chk("frame_hs_count",   32'(hs_cnt),   32'd30);
    chk("frame_hs_first",   32'(hs_first), 32'd10);
    chk("frame_vs_count",   32'(vs_cnt),   32'd32);
    chk("frame_vs_first",   32'(vs_first), 32'd112);
    chk("frame_vs_last",    32'(vs_last),  32'd143);
    chk("frame_vs_misalign", 32'(misalign), 32'd0);
    chk("frame_ls_count",   32'(ls_cnt),   32'd10);
    chk("frame_fs_extra",   32'(fs_cnt),   32'd0);
    chk("frame_seq_err",    32'(seq_err),  32'd0);
    step(1);
    chk("frame_wrap_fs", 32'(fs_b), 32'd1);
    chk("frame_wrap_sx", 32'(sx_b), 32'd0);
    chk("frame_wrap_sy", 32'(sy_b), 32'd0);

    // Lock loss mid-frame on the small instance at (5,4).
    step(69);
    chk("b_loss_sx_before", 32'(sx_b), 32'd5);
    chk("b_loss_sy_before", 32'(sy_b), 32'd4);
    lock_b = 1'b0;
    step(2);
    chk("b_loss_e2_running", 32'(run_b), 32'd1);
    chk("b_loss_e2_sx",      32'(sx_b),  32'd7);
    step(1);
    chk("b_loss_e3_running", 32'(run_b), 32'd0);
    chk("b_loss_e3_sx",      32'(sx_b),  32'd0);
    chk("b_loss_e3_sy",      32'(sy_b),  32'd0);
    chk("b_loss_e3_hsync",   32'(hs_b),  32'd1);
    chk("b_loss_e3_vsync",   32'(vs_b),  32'd1);
    chk("b_loss_e3_de",      32'(de_b),  32'd0);
    lock_b = 1'b1;
    step(3);
    chk("b_relock_fs", 32'(fs_b), 32'd1);
    chk("b_relock_sx", 32'(sx_b), 32'd0);
    chk("b_relock_sy", 32'(sy_b), 32'd0);
    chk("b_relock_de", 32'(de_b), 32'd1);

    // Asynchronous reset while both instances are running, between clock edges.
    step(5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_running_a", 32'(run_a), 32'd0);
    chk("async_rst_sx_a",      32'(sx_a),  32'd0);
    chk("async_rst_running_b", 32'(run_b), 32'd0);
    chk("async_rst_hsync_b",   32'(hs_b),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
